// File: rtl/minterm_sweep_ctrl.sv
// minterm_sweep_ctrl
//
// Purpose:
//   Walks a combinational circuit-under-test through every input vector
//   0 .. 2^N_IN-1 in ascending order. Each vector is held for SETTLE cycles
//   and the CUT output is then sampled. The index of every vector that makes
//   the CUT output 1 is queued in a small first-word-fall-through FIFO. A
//   downstream minimizer drains the FIFO with valid/ready.
//
// Ports:
//   clk            in   1        clock, all state on the rising edge
//   rst_n          in   1        asynchronous active-low reset
//   start          in   1        pulse, begins a sweep when idle
//   abort          in   1        cancels a sweep in progress and flushes the FIFO
//   cut_in         out  N_IN     vector driven to the CUT
//   cut_out        in   1        CUT response to cut_in
//   m_valid        out  1        minterm present at the FIFO head
//   m_ready        in   1        downstream accepts the head entry
//   m_index        out  N_IN     minterm index at the FIFO head (0 when empty)
//   busy           out  1        sweep in progress
//   done           out  1        one-cycle pulse, sweep finished and FIFO drained
//   minterm_count  out  N_IN+1   minterms found in the current/last sweep

module minterm_sweep_ctrl #(
    parameter int N_IN       = 13,
    parameter int SETTLE     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] cut_in,
    input  logic            cut_out,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N_IN-1:0] m_index,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   minterm_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CNT_W = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]   settle_cnt;
    logic [N_IN-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            empty, full, push, pop, flush;
    logic            start_sweep, next_vector;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && m_ready;
    assign m_valid = !empty;
    assign m_index = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full FIFO only blocks a sample when nothing leaves in the same
    // cycle; the slot being popped is reused by the push.
    always_comb begin
        state_next  = state;
        push        = 1'b0;
        flush       = 1'b0;
        start_sweep = 1'b0;
        next_vector = 1'b0;
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
            flush      = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        start_sweep = 1'b1;
                        state_next  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_next = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (!(cut_out && full && !pop)) begin
                        push = cut_out;
                        if (cut_in == LAST_VEC) begin
                            state_next = S_DRAIN;
                        end else begin
                            next_vector = 1'b1;
                            state_next  = S_SETTLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Vector, settle timer and minterm counter. cut_in and the count are
    // left untouched after a sweep so the last result stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut_in        <= '0;
            settle_cnt    <= '0;
            minterm_count <= '0;
        end else begin
            if (start_sweep) begin
                cut_in        <= '0;
                settle_cnt    <= SETTLE_LOAD;
                minterm_count <= '0;
            end else begin
                if (next_vector) begin
                    cut_in     <= cut_in + N_IN'(1);
                    settle_cnt <= SETTLE_LOAD;
                end else if (state == S_SETTLE && settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - CW'(1);
                end
                if (push) begin
                    minterm_count <= minterm_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset; the head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cut_in;
        end
    end

endmodule
